// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: LSU_OP fields, access sizes,
// error codes and FSM states.
package lsu_pkg;

  localparam int OP_LD    = 0;
  localparam int OP_ST    = 1;
  localparam int OP_SZ_LO = 2;
  localparam int OP_SZ_HI = 3;
  localparam int OP_SEXT  = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_WB     = 2'b10
  } state_e;

endpackage

// File: rtl/lsu_if.sv
// Simple req/ack data bus between the load/store unit (master) and memory (slave).
interface lsu_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [29:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
    input  MEM_ACK, MEM_RDATA
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
    output MEM_ACK, MEM_RDATA
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering shared by both directions: byte enables and replicated write
// data for stores, right-shift and zero/sign extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] d_i,
  input  logic [31:0] rdata_i,
  input  logic        sext_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [31:0] rdata_sh;

  always_comb begin
    rdata_sh = rdata_i >> {off_i, 3'b000};
    be_o     = 4'b1111;
    wdata_o  = d_i;
    ldata_o  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{d_i[7:0]}};
        ldata_o = {{24{sext_i & rdata_sh[7]}}, rdata_sh[7:0]};
      end
      SZ_HALF: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{d_i[15:0]}};
        ldata_o = {{16{sext_i & rdata_sh[15]}}, rdata_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: validates one op per idle cycle, runs a single req/ack bus
// access with optional timeout, and writes extended load data back.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic [5:0]  LSU_OP,
  input  logic [31:0] D,
  input  logic [31:0] O,
  input  logic [4:0]  LD_RA,
  output logic        STALL,
  lsu_if.master       mem,
  output logic        LWE,
  output logic [4:0]  WA,
  output logic [31:0] LWD,
  output logic        ERR,
  output logic [1:0]  ERR_CODE
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam bit         TO_EN  = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d, lwd_q, lwd_d;
  logic [1:0]  size_q, size_d, off_q, off_d, errc_q, errc_d;
  logic        sext_q, sext_d, ld_q, ld_d, lwe_q, lwe_d, err_q, err_d;
  logic [4:0]  ra_q, ra_d;

  logic        idle, op_vld, illegal, misalign;
  logic [1:0]  op_sz;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;
  logic        unused_op5;

  assign unused_op5 = LSU_OP[5];
  assign idle       = (state_q == S_IDLE);
  assign op_sz      = LSU_OP[OP_SZ_HI:OP_SZ_LO];
  assign op_vld     = LSU_OP[OP_LD] | LSU_OP[OP_ST];
  assign illegal    = (LSU_OP[OP_ST:OP_LD] == 2'b11) || (op_sz == SZ_RSVD);
  assign misalign   = ((op_sz == SZ_HALF) && O[0]) || ((op_sz == SZ_WORD) && (O[1:0] != 2'b00));

  // Aligner sees the incoming op while idle, the latched access otherwise.
  lsu_align u_align (
    .size_i  (idle ? op_sz : size_q),
    .off_i   (idle ? O[1:0] : off_q),
    .d_i     (D),
    .rdata_i (mem.MEM_RDATA),
    .sext_i  (idle ? LSU_OP[OP_SEXT] : sext_q),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .ldata_o (al_ldata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    sext_d  = sext_q;
    ld_d    = ld_q;
    ra_d    = ra_q;
    lwd_d   = lwd_q;
    errc_d  = errc_q;
    lwe_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_vld) begin
          if (illegal) begin
            err_d  = 1'b1;
            errc_d = ERR_ILLEGAL;
          end else if (misalign) begin
            err_d  = 1'b1;
            errc_d = ERR_MISALIGN;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = LSU_OP[OP_ST];
            addr_d  = O[31:2];
            be_d    = al_be;
            wdata_d = al_wdata;
            size_d  = op_sz;
            off_d   = O[1:0];
            sext_d  = LSU_OP[OP_SEXT];
            ld_d    = LSU_OP[OP_LD];
            ra_d    = LD_RA;
          end
        end
      end
      S_ACCESS: begin
        // ACK takes priority over a timeout landing in the same cycle.
        if (mem.MEM_ACK) begin
          req_d = 1'b0;
          if (ld_q) begin
            lwd_d   = al_ldata;
            lwe_d   = 1'b1;
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end else if (TO_EN && (cnt_q == TO_LIM)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          errc_d  = ERR_TIMEOUT;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      sext_q  <= 1'b0;
      ld_q    <= 1'b0;
      ra_q    <= '0;
      lwd_q   <= '0;
      lwe_q   <= 1'b0;
      err_q   <= 1'b0;
      errc_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sext_q  <= sext_d;
      ld_q    <= ld_d;
      ra_q    <= ra_d;
      lwd_q   <= lwd_d;
      lwe_q   <= lwe_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

  assign STALL         = !idle;
  assign mem.MEM_REQ   = req_q;
  assign mem.MEM_WE    = we_q;
  assign mem.MEM_ADDR  = addr_q;
  assign mem.MEM_BE    = be_q;
  assign mem.MEM_WDATA = wdata_q;
  assign LWE           = lwe_q;
  assign WA            = ra_q;
  assign LWD           = lwd_q;
  assign ERR           = err_q;
  assign ERR_CODE      = errc_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed and randomized bench for lsu_unit against a byte-lane reference model.
module tb_lsu_unit;

  localparam int TO = 4;

  logic        CLK;
  logic        N_RST;
  logic [5:0]  LSU_OP;
  logic [31:0] D, O;
  logic [4:0]  LD_RA;
  logic        STALL, LWE, ERR;
  logic [4:0]  WA;
  logic [31:0] LWD;
  logic [1:0]  ERR_CODE;

  int ntests = 0;
  int nfail  = 0;

  lsu_if bus ();

  lsu_unit #(.TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .N_RST    (N_RST),
    .LSU_OP   (LSU_OP),
    .D        (D),
    .O        (O),
    .LD_RA    (LD_RA),
    .STALL    (STALL),
    .mem      (bus),
    .LWE      (LWE),
    .WA       (WA),
    .LWD      (LWD),
    .ERR      (ERR),
    .ERR_CODE (ERR_CODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    bit        valid;
    bit [1:0]  err;
    bit        is_ld;
    bit [29:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
    bit [31:0] ldata;
  } exp_t;

  // Expected behaviour computed from byte-lane arithmetic on the op fields.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] d, o, rdata);
    exp_t        e;
    int          nb, lane, base;
    logic [31:0] v, mask;
    e       = '0;
    e.valid = (op[1:0] != 2'b00);
    nb      = 1 << op[3:2];
    lane    = int'(o % 4);
    if (op[1:0] == 2'b11 || op[3:2] == 2'b11) e.err = 2'b11;
    else if ((o % nb) != 0)                   e.err = 2'b01;
    e.is_ld = op[0];
    e.addr  = 30'(o / 4);
    if (nb == 4) begin
      e.be    = 4'hF;
      e.wdata = d;
      e.ldata = rdata;
    end else if (nb < 4) begin
      base    = (nb == 1) ? lane : (lane / 2) * 2;
      e.be    = 4'(((1 << nb) - 1) << base);
      e.wdata = (nb == 1) ? (d & 32'hFF) * 32'h01010101 : (d & 32'hFFFF) * 32'h00010001;
      mask    = (32'd1 << (8 * nb)) - 32'd1;
      v       = (rdata >> (8 * lane)) & mask;
      if (op[4] && v[8 * nb - 1]) v = v | ~mask;
      e.ldata = v;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] d, o, input logic [4:0] ra,
                        input int waits, input logic [31:0] rdata);
    exp_t e;
    e      = model(op, d, o, rdata);
    LSU_OP = op;
    D      = d;
    O      = o;
    LD_RA  = ra;
    chk("accept_stall", STALL, 0);
    tick();
    LSU_OP = 6'd0;
    D      = $urandom;
    O      = $urandom;
    LD_RA  = 5'($urandom);
    if (!e.valid) begin
      chk("nop_req", bus.MEM_REQ, 0);
      chk("nop_err", ERR, 0);
      chk("nop_stall", STALL, 0);
      return;
    end
    if (e.err != 2'b00) begin
      chk("rej_err", ERR, 1);
      chk("rej_code", ERR_CODE, e.err);
      chk("rej_req", bus.MEM_REQ, 0);
      chk("rej_stall", STALL, 0);
      chk("rej_lwe", LWE, 0);
      return;
    end
    for (int k = 0; k <= waits && k <= TO; k++) begin
      chk("acc_req", bus.MEM_REQ, 1);
      chk("acc_we", bus.MEM_WE, !e.is_ld);
      chk("acc_addr", bus.MEM_ADDR, e.addr);
      chk("acc_be", bus.MEM_BE, e.be);
      if (!e.is_ld) chk("acc_wdata", bus.MEM_WDATA, e.wdata);
      chk("acc_stall", STALL, 1);
      chk("acc_err", ERR, 0);
      if (k == waits) begin
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = rdata;
      end
      tick();
      bus.MEM_ACK   = 1'b0;
      bus.MEM_RDATA = $urandom;
    end
    if (waits > TO) begin
      chk("to_err", ERR, 1);
      chk("to_code", ERR_CODE, 2'b10);
      chk("to_req", bus.MEM_REQ, 0);
      chk("to_lwe", LWE, 0);
      chk("to_stall", STALL, 0);
      return;
    end
    chk("done_req", bus.MEM_REQ, 0);
    if (e.is_ld) begin
      chk("wb_lwe", LWE, 1);
      chk("wb_wa", WA, ra);
      chk("wb_lwd", LWD, e.ldata);
      chk("wb_stall", STALL, 1);
      tick();
      chk("wb_lwe_end", LWE, 0);
      chk("wb_stall_end", STALL, 0);
    end else begin
      chk("st_stall_end", STALL, 0);
      chk("st_lwe", LWE, 0);
    end
  endtask

  initial begin
    N_RST         = 1'b0;
    LSU_OP        = 6'd0;
    D             = '0;
    O             = '0;
    LD_RA         = '0;
    bus.MEM_ACK   = 1'b0;
    bus.MEM_RDATA = '0;
    tick();
    tick();
    chk("rst_req", bus.MEM_REQ, 0);
    chk("rst_stall", STALL, 0);
    chk("rst_lwe", LWE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_lwd", LWD, 0);
    chk("rst_addr", bus.MEM_ADDR, 0);
    N_RST = 1'b1;
    tick();

    // Store byte at 0x1003, zero-wait
    run_op(6'b000010, 32'h000000A5, 32'h1003, 5'd0, 0, 32'h0);
    // Half loads at 0x22, signed then unsigned, three wait cycles
    run_op(6'b010101, 32'h0, 32'h22, 5'd7, 3, 32'h8001FFFF);
    run_op(6'b000101, 32'h0, 32'h22, 5'd7, 3, 32'h8001FFFF);
    // Misaligned word load, illegal op
    run_op(6'b001001, 32'h0, 32'h6, 5'd1, 0, 32'h0);
    run_op(6'b000011, 32'h0, 32'h0, 5'd1, 0, 32'h0);
    // Timeout on a load, ACK exactly at the limit, then a normal store
    run_op(6'b001001, 32'h0, 32'h40, 5'd3, 100, 32'h0);
    run_op(6'b001001, 32'h0, 32'h44, 5'd4, TO, 32'hCAFEF00D);
    run_op(6'b000110, 32'h1234BEEF, 32'h52, 5'd0, 0, 32'h0);

    // Reset in the middle of a waited load
    LSU_OP = 6'b010101;
    O      = 32'h22;
    LD_RA  = 5'd9;
    chk("rl_accept_stall", STALL, 0);
    tick();
    LSU_OP = 6'd0;
    chk("rl_req1", bus.MEM_REQ, 1);
    tick();
    chk("rl_req2", bus.MEM_REQ, 1);
    #2 N_RST = 1'b0;
    #1;
    chk("rl_async_req", bus.MEM_REQ, 0);
    chk("rl_async_stall", STALL, 0);
    chk("rl_async_lwe", LWE, 0);
    tick();
    N_RST         = 1'b1;
    bus.MEM_ACK   = 1'b1;
    bus.MEM_RDATA = 32'h87654321;
    tick();
    bus.MEM_ACK = 1'b0;
    chk("rl_late_lwe", LWE, 0);
    chk("rl_late_req", bus.MEM_REQ, 0);
    chk("rl_late_stall", STALL, 0);
    tick();
    chk("rl_late_lwe2", LWE, 0);

    // Back-to-back word store then word load
    run_op(6'b001010, 32'hDEADBEEF, 32'h100, 5'd0, 0, 32'h0);
    run_op(6'b001001, 32'h0, 32'h104, 5'd12, 0, 32'h13579BDF);
    tick();
    chk("b2b_no_dup_req", bus.MEM_REQ, 0);
    chk("b2b_idle_stall", STALL, 0);

    // Randomized ops, including reserved encodings and timeouts
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  rop;
      logic [31:0] ro;
      rop = 6'($urandom);
      ro  = $urandom_range(0, 255);
      run_op(rop, $urandom, ro, 5'($urandom), int'($urandom_range(0, 6)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit on the execute-side interface. Consumes the ALU's LSU_OP, D (store data) and O (effective byte address).
- Performs one memory access over a simple req/ack data bus.
- Aligns store data, extracts and extends load data, and writes load results back to the register file.
- Stalls the pipeline while an access is outstanding, and flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 255: maximum cycles MEM_REQ stays high without MEM_ACK before the access aborts. 0 disables the timeout. Counter width is 8 bits; legal range is 0..255.

Ports:
- CLK  in  1  clock, rising edge
- N_RST  in  1  asynchronous active-low reset
- LSU_OP  in  6  [0] load, [1] store, [3:2] size (00 byte, 01 half, 10 word, 11 reserved), [4] sign-extend load, [5] ignored
- D  in  32  store data, LSB-aligned
- O  in  32  effective byte address
- LD_RA  in  5  destination register for a load
- STALL  out  1  unit busy; upstream must hold and must not present a new op
- MEM_REQ  out  1  bus request
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  30  word address (O[31:2])
- MEM_BE  out  4  byte enables, little-endian
- MEM_WDATA  out  32  lane-replicated write data
- MEM_ACK  in  1  access complete; for reads, MEM_RDATA is valid in the same cycle
- MEM_RDATA  in  32  read data
- LWE  out  1  load writeback enable (1-cycle pulse)
- WA  out  5  writeback register
- LWD  out  32  writeback data
- ERR  out  1  error pulse
- ERR_CODE  out  2  01 misaligned, 10 timeout, 11 illegal op; valid while ERR=1

Behaviour:
- All outputs are registered except STALL.
- Reset (async, N_RST=0) forces state IDLE, counter 0, and every output to 0. MEM_REQ drops immediately, including mid-access; an in-flight ACK after reset is ignored.
- States: IDLE, ACCESS, WB.
- An op is valid when LSU_OP[1:0] != 00. It is accepted only in IDLE.
- STALL = (state != IDLE), combinational. The accept cycle has STALL=0, so upstream advances and the op is consumed exactly once.
- Accept checks, in priority order:
  - LSU_OP[1:0]=11 or size=11 → illegal.
  - half with O[0]=1 → misaligned.
  - word with O[1:0]!=00 → misaligned.
  - On illegal or misaligned: no bus access, state stays IDLE, and ERR=1 with the matching code in the next cycle.
- Legal accept: latch the access fields, go to ACCESS, and assert MEM_REQ in the next cycle.
- ACCESS:
  - MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE and MEM_WDATA are held stable until MEM_ACK is sampled high.
  - Timeout counter starts at 0 and increments each cycle without ACK.
  - ACK on a store → deassert MEM_REQ next cycle, go to IDLE.
  - ACK on a load → capture and extend data, go to WB.
  - Counter reaching TIMEOUT without ACK → deassert MEM_REQ next cycle, pulse ERR with code 10, go to IDLE, no writeback.
  - ACK in the same cycle the counter reaches TIMEOUT → ACK wins.
- WB: LWE=1, WA=LD_RA latched, LWD=extended data for one cycle, then IDLE.
- Latencies:
  - Store: accept at N, MEM_REQ at N+1, zero-wait ACK at N+1, STALL low again at N+2.
  - Load: same as store, plus LWE at N+2 and STALL low at N+3.
- Store lanes:
  - Byte: MEM_WDATA={4{D[7:0]}}, MEM_BE=0001<<O[1:0].
  - Half: MEM_WDATA={2{D[15:0]}}, MEM_BE = O[1] ? 1100 : 0011.
  - Word: MEM_WDATA=D, MEM_BE=1111.
- Loads: MEM_WE=0, MEM_BE as for a store of the same size.
- Load extraction: shift MEM_RDATA right by 8*O[1:0]. Keep 8 or 16 bits and zero- or sign-extend per LSU_OP[4]. Word loads ignore bit 4.
- Idle bus outputs hold their last values except MEM_REQ=0. LWE and ERR are 0 outside their pulse cycles.

Decomposition:
- Shared package lsu_pkg:
  - LSU_OP bit indices.
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - ERR_CODE constants.
  - State encoding.
- One sub-module, lsu_align: purely combinational. Inputs are size, O[1:0], D, RDATA and sign-extend. Outputs are BE, WDATA and the extended load data. It is shared by the store and load paths.

Test Plan:
- Store byte, O=0x1003, D=0x000000A5, zero-wait ACK → MEM_ADDR=0x400, MEM_BE=1000, MEM_WDATA=0xA5A5A5A5, MEM_WE=1, STALL high for 1 cycle, no LWE.
- Load half signed, O=0x22, LD_RA=7, RDATA=0x8001FFFF, ACK after 3 waits → MEM_BE=1100, request stable for 4 cycles, then LWE=1, WA=7, LWD=0xFFFF8001. Repeat unsigned → LWD=0x00008001.
- Word load at O=0x6 → no MEM_REQ, ERR=1 with code 01 next cycle, STALL stays 0. LSU_OP=0b000011 → ERR code 11.
- TIMEOUT=4 and ACK never asserted → MEM_REQ high for exactly 5 cycles, then ERR code 10, no LWE, unit returns to IDLE and accepts a following store normally.
- N_RST pulled low two cycles into a waited load → MEM_REQ, LWE and STALL drop asynchronously. A late ACK after release produces no writeback.
- Back-to-back word store then load, each with zero-wait ACK → each op accepted once, load LWD equals RDATA, and no duplicate access.
